// File: rtl/fpga_cfg_pkg.sv
// Shared constants and loader state type for the FPGA configuration path.
// Word map: LUT truth tables, then switch boxes, then LUT FF-select bits.
package fpga_cfg_pkg;

  localparam int NUM_LUT = 11;
  localparam int NUM_SB = 20;
  localparam int WORD_W = 32;
  localparam int N_WORDS = 2 * NUM_LUT + NUM_SB;
  localparam int AW = $clog2(N_WORDS + 1);

  localparam int LUT_TT_BASE = 0;
  localparam int SB_BASE = NUM_LUT;
  localparam int LUT_FF_BASE = NUM_LUT + NUM_SB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

endpackage

// File: rtl/fpga_cfg_decode.sv
// Turns the loader's single-target write bus into per-element write enables.
// Lives at the FPGA top next to the fabric, not inside the loader.
module fpga_cfg_decode
  import fpga_cfg_pkg::*;
(
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_sel,
  output logic [NUM_LUT-1:0] lut_tt_we,
  output logic [NUM_SB-1:0]  sb_we,
  output logic [NUM_LUT-1:0] lut_ff_we
);

  always_comb begin
    lut_tt_we = '0;
    sb_we = '0;
    lut_ff_we = '0;
    for (int i = 0; i < NUM_LUT; i++) begin
      lut_tt_we[i] = cfg_we && (cfg_sel == AW'(LUT_TT_BASE + i));
      lut_ff_we[i] = cfg_we && (cfg_sel == AW'(LUT_FF_BASE + i));
    end
    for (int i = 0; i < NUM_SB; i++) begin
      sb_we[i] = cfg_we && (cfg_sel == AW'(SB_BASE + i));
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams the config image from memory into the fabric, XOR-checks it,
// and keeps the fabric held until a load completes with a good checksum.
module fpga_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              cfg_we,
  output logic [AW-1:0]     cfg_sel,
  output logic [WORD_W-1:0] cfg_data,
  output logic              fabric_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ld_state_e         state;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] chk;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      mem_rd_en <= 1'b0;
      mem_addr <= '0;
      cfg_we <= 1'b0;
      cfg_sel <= '0;
      cfg_data <= '0;
      fabric_hold <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      chk <= '0;
      idx <= '0;
    end else begin
      cfg_we <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            idx <= '0;
            chk <= '0;
            done <= 1'b0;
            error <= 1'b0;
            fabric_hold <= 1'b1;
            busy <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          mem_rd_en <= 1'b0;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (idx < AW'(N_WORDS)) begin
            cfg_we <= 1'b1;
            cfg_sel <= idx;
            cfg_data <= mem_rdata;
            chk <= chk ^ mem_rdata;
            idx <= idx + 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr <= idx + 1'b1;
            state <= ST_FETCH;
          end else begin
            busy <= 1'b0;
            // Checksum word is compared only; it never reaches the fabric.
            if (chk == mem_rdata) begin
              done <= 1'b1;
              fabric_hold <= 1'b0;
              state <= ST_DONE;
            end else begin
              error <= 1'b1;
              state <= ST_ERROR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized bench for fpga_config_loader against an image-level reference.
// Cycle c counts rising edges after the edge that samples start.
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              cfg_we;
  logic [AW-1:0]     cfg_sel;
  logic [WORD_W-1:0] cfg_data;
  logic              fabric_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [NUM_LUT-1:0] lut_tt_we;
  logic [NUM_SB-1:0]  sb_we;
  logic [NUM_LUT-1:0] lut_ff_we;

  logic [WORD_W-1:0] mem [0:N_WORDS];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_rd_en) mem_rdata <= mem[mem_addr];

  fpga_config_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .fabric_hold(fabric_hold), .busy(busy), .done(done), .error(error)
  );

  fpga_cfg_decode dec (
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .lut_tt_we(lut_tt_we), .sb_we(sb_we), .lut_ff_we(lut_ff_we)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // mode 0: k*0x01010101, mode 1: random. bad flips checksum bit 0.
  task automatic fill_image(input int mode, input bit bad);
    logic [WORD_W-1:0] x;
    x = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      mem[k] = (mode == 0) ? WORD_W'(k) * 32'h01010101 : $urandom;
      x = x ^ mem[k];
    end
    mem[N_WORDS] = bad ? (x ^ 32'h1) : x;
  endtask

  task automatic check_reset_vals();
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", cfg_we, 0);
    check("rst_sel", cfg_sel, 0);
    check("rst_data", cfg_data, 0);
    check("rst_hold", fabric_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
  endtask

  task automatic run_load(input bit good, input bit extra, input int abort_c);
    int last_c;
    bit wr, rd, fin;
    int k;
    logic [63:0] e_tt, e_sb, e_ff;
    last_c = 2 + 2 * N_WORDS + 4;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clock);
      start = extra && (c == 10 || c == 40);
      if (abort_c >= 0 && c == abort_c + 1) begin
        check_reset_vals();
        reset_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clock);
          check("abort_no_we", cfg_we, 0);
          check("abort_busy", busy, 0);
        end
        return;
      end
      k = (c - 2) / 2;
      wr = c >= 2 && c % 2 == 0 && k < N_WORDS;
      rd = c % 2 == 0 && c / 2 <= N_WORDS;
      fin = c >= 2 + 2 * N_WORDS;
      check("cfg_we", cfg_we, wr);
      if (wr) begin
        check("cfg_sel", cfg_sel, k);
        check("cfg_data", cfg_data, mem[k]);
        e_tt = (k < NUM_LUT) ? (64'd1 << k) : 0;
        e_sb = (k >= NUM_LUT && k < NUM_LUT + NUM_SB) ?
               (64'd1 << (k - NUM_LUT)) : 0;
        e_ff = (k >= NUM_LUT + NUM_SB) ?
               (64'd1 << (k - NUM_LUT - NUM_SB)) : 0;
        check("dec_tt", lut_tt_we, e_tt);
        check("dec_sb", sb_we, e_sb);
        check("dec_ff", lut_ff_we, e_ff);
      end
      check("mem_rd_en", mem_rd_en, rd);
      if (rd) check("mem_addr", mem_addr, c / 2);
      check("busy", busy, !fin);
      check("done", done, fin && good);
      check("error", error, fin && !good);
      check("hold", fabric_hold, !(fin && good));
      if (abort_c >= 0 && c == abort_c) reset_n = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);

    fill_image(0, 1'b0);
    run_load(1'b1, 1'b0, -1);
    fill_image(0, 1'b1);
    run_load(1'b0, 1'b0, -1);
    fill_image(0, 1'b0);
    run_load(1'b1, 1'b1, -1);
    run_load(1'b1, 1'b0, 2 + 2 * 20);
    run_load(1'b1, 1'b0, -1);
    run_load(1'b1, 1'b0, -1);

    for (int t = 0; t < 8; t++) begin
      bit bad;
      bad = $urandom_range(0, 2) == 0;
      fill_image(1, bad);
      run_load(!bad, $urandom_range(0, 1) == 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
